// File: rtl/vid_bbox_tracker.sv
`default_nettype none
// ============================================================================
// Module   : vid_bbox_tracker
// Brief    : Avalon-ST RGB pass-through (1-cycle latency) that builds a per-
//            frame colour-window bounding box, published over Avalon-MM.
//            Optional perimeter overlay: define VID_BBOX_OVERLAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vid_bbox_tracker #(
    parameter int IMAGE_W    = 640,
    parameter int IMAGE_H    = 480,
    parameter int MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,
    input  logic [2:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata
);
    localparam logic [10:0] c_x_last     = 11'(IMAGE_W - 1);
    localparam logic [10:0] c_y_limit    = 11'(IMAGE_H);
    localparam logic [19:0] c_min_pixels = 20'(MIN_PIXELS);

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        VIDEO    = 2'd1,
        SKIP     = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_x, r_y;
    logic [10:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [19:0] r_cnt;
    logic [23:0] r_lo, r_hi;
    logic [10:0] r_pxmin, r_pxmax, r_pymin, r_pymax;
    logic [19:0] r_pcnt;
    logic        r_found, r_new;
    logic [15:0] r_frame_cnt;

    logic        w_xfer, w_clear, w_pixel, w_latch, w_match, w_hit;
    logic [10:0] w_xmin_nxt, w_xmax_nxt, w_ymin_nxt, w_ymax_nxt;
    logic [19:0] w_cnt_nxt;
    logic [23:0] w_out_data;
    logic        w_unused;

    assign sink_ready = ~source_valid | source_ready;
    assign w_xfer     = sink_valid & sink_ready;
    assign w_pixel    = w_xfer & ~sink_sop & (r_state == VIDEO);
    assign w_latch    = w_pixel & sink_eop;
    assign w_unused   = &{1'b0, s_writedata[31:24]};

    // lo > hi in any channel fails its own compare, so nothing matches
    assign w_hit = (sink_data[23:16] >= r_lo[23:16]) && (sink_data[23:16] <= r_hi[23:16])
                && (sink_data[15:8]  >= r_lo[15:8])  && (sink_data[15:8]  <= r_hi[15:8])
                && (sink_data[7:0]   >= r_lo[7:0])   && (sink_data[7:0]   <= r_hi[7:0]);
    assign w_match = w_pixel & (r_y < c_y_limit) & w_hit;

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        if (w_xfer) begin
            if (sink_sop) begin
                w_clear     = (sink_data[3:0] == 4'd0);
                w_state_nxt = (sink_data[3:0] == 4'd0) ? VIDEO : SKIP;
                if (sink_eop) w_state_nxt = WAIT_SOP;
            end else if (sink_eop) begin
                w_state_nxt = WAIT_SOP;
            end
        end
    end

    // Includes the current pixel so an EOP pixel is part of the latched result
    always_comb begin
        w_xmin_nxt = r_xmin;
        w_xmax_nxt = r_xmax;
        w_ymin_nxt = r_ymin;
        w_ymax_nxt = r_ymax;
        w_cnt_nxt  = r_cnt;
        if (w_match) begin
            if (r_cnt == 20'd0) begin
                w_xmin_nxt = r_x;
                w_xmax_nxt = r_x;
                w_ymin_nxt = r_y;
                w_ymax_nxt = r_y;
            end else begin
                if (r_x < r_xmin) w_xmin_nxt = r_x;
                if (r_x > r_xmax) w_xmax_nxt = r_x;
                if (r_y < r_ymin) w_ymin_nxt = r_y;
                if (r_y > r_ymax) w_ymax_nxt = r_y;
            end
            if (r_cnt != 20'hFFFFF) w_cnt_nxt = r_cnt + 20'd1;
        end
    end

`ifdef VID_BBOX_OVERLAY_EN
    logic w_on_box;
    assign w_on_box = r_found & w_pixel &
                      ((((r_x == r_pxmin) || (r_x == r_pxmax)) && (r_y >= r_pymin) && (r_y <= r_pymax)) ||
                       (((r_y == r_pymin) || (r_y == r_pymax)) && (r_x >= r_pxmin) && (r_x <= r_pxmax)));
    assign w_out_data = w_on_box ? 24'h00FF00 : sink_data;
`else
    assign w_out_data = sink_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_data  <= 24'd0;
        end else if (w_xfer) begin
            source_valid <= 1'b1;
            source_sop   <= sink_sop;
            source_eop   <= sink_eop;
            source_data  <= w_out_data;
        end else if (source_ready) begin
            source_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_SOP;
            r_x     <= '0;
            r_y     <= '0;
            r_xmin  <= '0;
            r_xmax  <= '0;
            r_ymin  <= '0;
            r_ymax  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_x    <= '0;
                r_y    <= '0;
                r_xmin <= '0;
                r_xmax <= '0;
                r_ymin <= '0;
                r_ymax <= '0;
                r_cnt  <= '0;
            end else if (w_pixel) begin
                r_xmin <= w_xmin_nxt;
                r_xmax <= w_xmax_nxt;
                r_ymin <= w_ymin_nxt;
                r_ymax <= w_ymax_nxt;
                r_cnt  <= w_cnt_nxt;
                if (r_x == c_x_last) begin
                    r_x <= '0;
                    if (r_y != c_y_limit) r_y <= r_y + 11'd1;
                end else begin
                    r_x <= r_x + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo        <= 24'h000000;
            r_hi        <= 24'hFFFFFF;
            r_pxmin     <= '0;
            r_pxmax     <= '0;
            r_pymin     <= '0;
            r_pymax     <= '0;
            r_pcnt      <= '0;
            r_found     <= 1'b0;
            r_new       <= 1'b0;
            r_frame_cnt <= '0;
            s_readdata  <= '0;
        end else begin
            if (w_latch) begin
                r_pxmin     <= (w_cnt_nxt == 20'd0) ? 11'd0 : w_xmin_nxt;
                r_pxmax     <= (w_cnt_nxt == 20'd0) ? 11'd0 : w_xmax_nxt;
                r_pymin     <= (w_cnt_nxt == 20'd0) ? 11'd0 : w_ymin_nxt;
                r_pymax     <= (w_cnt_nxt == 20'd0) ? 11'd0 : w_ymax_nxt;
                r_pcnt      <= w_cnt_nxt;
                r_found     <= (w_cnt_nxt >= c_min_pixels);
                r_frame_cnt <= r_frame_cnt + 16'd1;
                r_new       <= 1'b1;
            end else if (s_write && (s_address == 3'd0)) begin
                r_new <= 1'b0;
            end
            if (s_write && (s_address == 3'd1)) r_lo <= s_writedata[23:0];
            if (s_write && (s_address == 3'd2)) r_hi <= s_writedata[23:0];
            if (s_read) begin
                case (s_address)
                    3'd0:    s_readdata <= {r_frame_cnt, 14'd0, r_new, r_found};
                    3'd1:    s_readdata <= {8'd0, r_lo};
                    3'd2:    s_readdata <= {8'd0, r_hi};
                    3'd3:    s_readdata <= {5'd0, r_pymin, 5'd0, r_pxmin};
                    3'd4:    s_readdata <= {5'd0, r_pymax, 5'd0, r_pxmax};
                    3'd5:    s_readdata <= {12'd0, r_pcnt};
                    default: s_readdata <= 32'd0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/vid_bbox_tracker.md
# vid_bbox_tracker

Avalon-ST video stage between the colour image-processing filter and the clocked-video output (ITC) of the rover vision pipeline. Passes 24-bit RGB video unchanged with one cycle of latency. Marks each video pixel whose colour falls inside a programmable RGB window, and builds a per-frame bounding box and hit count. At end of frame it publishes the result to Nios software through an Avalon-MM slave for target tracking and UART telemetry.

## Interface
- `IMAGE_W`, 640: active pixels per line.
- `IMAGE_H`, 480: active lines per frame.
- `MIN_PIXELS`, 64: minimum hit count for a frame to report `found`.

Ports:
- `clk` in 1: pipeline clock, the 50 MHz Qsys system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sink_data` in 24: RGB pixel, with R in [23:16], G in [15:8] and B in [7:0].
- `sink_valid` in 1, `sink_sop` in 1, `sink_eop` in 1: upstream stream qualifiers.
- `sink_ready` out 1: backpressure to upstream.
- `source_data` out 24, `source_valid` out 1, `source_sop` out 1, `source_eop` out 1: stream toward the ITC.
- `source_ready` in 1: backpressure from the ITC.
- `s_address` in 3, `s_read` in 1, `s_write` in 1, `s_writedata` in 32: Avalon-MM slave inputs.
- `s_readdata` out 32: Avalon-MM read data, 0 wait states.

## Operation
- **Pass-through.** `sink_ready = ~source_valid | source_ready`.
  - On a sink transfer, data, sop and eop are registered to the source.
  - Without `BBOX_OVERLAY_EN`, data is unmodified.
- **Parser FSM**, which advances on sink transfers only:
  - `WAIT_SOP`: on an SOP word with `data[3:0]==0`, go to `VIDEO` and clear x, y, the accumulators and the count. On an SOP word with any other type, go to `SKIP`.
  - `VIDEO`: each non-SOP word is a pixel at (x, y).
    - x increments and wraps at `IMAGE_W-1`; on wrap, y increments.
    - Pixels with `y >= IMAGE_H` are ignored, and y saturates.
    - EOP: latch the results and go to `WAIT_SOP`.
    - An SOP arriving in `VIDEO` abandons the frame with no latch and re-evaluates the type as in `WAIT_SOP`.
  - `SKIP`: EOP returns to `WAIT_SOP`. An SOP is handled as in `WAIT_SOP`.
- **Match rule.** A pixel matches when `lo_c <= c <= hi_c` for each of R, G and B, using unsigned 8-bit compares. If lo > hi in any channel, nothing matches.
- **Accumulation.** A match updates `x_min`, `x_max`, `y_min` and `y_max` (11 bits each) and increments the 20-bit count, which saturates at 0xFFFFF.
- **Latch at EOP.**
  - Copy the box and count to the published registers.
  - Set `found = (count >= MIN_PIXELS)`.
  - Increment the 16-bit `frame_cnt`, which wraps.
  - Set the sticky `new` flag.
  - When count is 0, the published box is 0.
- **Register map** (`s_address`):
  - 0 read: `{frame_cnt[31:16], 14'b0, new[1], found[0]}`. Any write to address 0 clears `new`.
  - 1 R/W: lo thresholds `{8'b0, R, G, B}`.
  - 2 R/W: hi thresholds, same layout as 1.
  - 3 read: `{5'b0, y_min[26:16], 5'b0, x_min[10:0]}`.
  - 4 read: `{5'b0, y_max[26:16], 5'b0, x_max[10:0]}`.
  - 5 read: `{12'b0, count[19:0]}`.
  - 6 and 7 read 0.
- **Threshold writes** take effect on the next pixel and may change mid-frame.
- **Simultaneous events.** If an EOP latch and a write to address 0 occur in the same cycle, `new` ends at 1.

## Timing
- Reset values:
  - `source_valid`, `source_sop`, `source_eop` = 0.
  - `source_data` = 0.
  - `s_readdata` = 0.
  - FSM = `WAIT_SOP`.
  - lo = 0x000000 and hi = 0xFFFFFF, so all pixels match.
  - Published registers, `found`, `new` and `frame_cnt` = 0.
- Stream latency is 1 cycle. There are no bubbles while `source_ready` is 1, giving full throughput.
- Held source: while `source_valid & ~source_ready`, all source outputs hold stable.
- `s_readdata` is registered and valid the cycle after `s_read`.
- Published values become visible to reads 1 cycle after the EOP transfer.
- Reset mid-frame discards the frame and drops any held output word.

## Configuration
- **`VID_BBOX_OVERLAY_EN` defined:** on a video pixel, output 0x00FF00 (green) when the pixel lies on the perimeter of the last published box and `found` = 1. The perimeter is x in {x_min, x_max} with y_min <= y <= y_max, or y in {y_min, y_max} with x_min <= x <= x_max. All other words pass unchanged. Latency is unchanged.
- **Undefined:** data passes bit-exact, and the overlay logic is absent.

## Test plan
- Reset, then 4x2 frame (build with `IMAGE_W`=4, `IMAGE_H`=2), with default thresholds -> output identical to input at 1-cycle latency; box (0,0)-(3,1); count 8; frame_cnt 1; `new` 1.
- lo=0xC00000, hi=0xFFFF40; red pixels at (1,0) and (2,1) only, `MIN_PIXELS`=2 -> box x 1..2, y 0..1; count 2; `found` 1.
- Control packet (header 0xF) followed by a video frame -> control packet passed through and ignored; only the video frame latches; frame_cnt +1.
- `source_ready` toggled randomly -> no data loss or duplication; source outputs stable while stalled; sink_ready follows the equation above.
- SOP mid-frame, then a complete frame with 0 matches -> no latch for the aborted frame; published count 0, box 0, `found` 0.
- With `VID_BBOX_OVERLAY_EN`: a second frame after a box of (1,0)-(2,1) -> perimeter pixels output 0x00FF00; all others unchanged.
